// File: rtl/alarm_pkg.sv
// Shared types and packed-BCD time layout for the alarm sequencing controller.
package alarm_pkg;

   localparam int TIME_W = 20;

   // Packed BCD time: hh:mm:ss, seconds in the low bits.
   localparam int SEC_U_LSB  = 0;
   localparam int SEC_U_MSB  = 3;
   localparam int SEC_T_LSB  = 4;
   localparam int SEC_T_MSB  = 6;
   localparam int MIN_U_LSB  = 7;
   localparam int MIN_U_MSB  = 10;
   localparam int MIN_T_LSB  = 11;
   localparam int MIN_T_MSB  = 13;
   localparam int HOUR_U_LSB = 14;
   localparam int HOUR_U_MSB = 17;
   localparam int HOUR_T_LSB = 18;
   localparam int HOUR_T_MSB = 19;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZING = 2'd3
   } alarm_state_e;

endpackage

// File: rtl/alarm_beep_gen.sv
// Buzzer square-wave generator; divider and phase are held at zero while disabled.
module alarm_beep_gen #(
   parameter int BEEP_HALF_PERIOD = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_beep
);

   localparam int DIV_W = (BEEP_HALF_PERIOD > 1) ? $clog2(BEEP_HALF_PERIOD) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_HALF_PERIOD - 1);

   logic [DIV_W-1:0] div;
   logic             phase;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div   <= '0;
         phase <= 1'b0;
      end else if (!i_en) begin
         div   <= '0;
         phase <= 1'b0;
      end else if (div == DIV_LAST) begin
         div   <= '0;
         phase <= ~phase;
      end else begin
         div   <= div + 1'b1;
      end
   end

   assign o_beep = phase;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm ring/snooze/stop/timeout sequencer with buzzer drive.
// Optional snooze limit: define ALARM_SNOOZE_LIMIT_EN.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_SECONDS       = 300,
   parameter int RING_TIMEOUT_SECONDS = 60,
   parameter int BEEP_HALF_PERIOD     = 1,
   parameter int MAX_SNOOZES          = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_tick_1hz,
   input  logic [TIME_W-1:0] i_cur_time,
   input  logic [TIME_W-1:0] i_alarm_time,
   input  logic              i_alarm_wr_en,
   input  logic              i_arm_toggle,
   input  logic              i_snooze,
   input  logic              i_stop,
   output logic [1:0]        o_state,
   output logic              o_buzzer,
   output logic              o_armed,
   output logic [15:0]       o_snooze_remaining
);

   localparam logic [15:0] RING_LOAD = 16'(RING_TIMEOUT_SECONDS);
   localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_SECONDS);

   alarm_state_e state_q, state_d;
   logic [15:0]  ring_cnt, ring_d;
   logic [15:0]  snz_cnt, snz_d;
   logic         match_q, match_rise;
   logic         armed_q;
   logic         snooze_ok;
   logic         beep_en;

   // Edge-detect the match so the alarm fires once per entry; edits never fire it.
   assign match_rise = (i_cur_time == i_alarm_time) & ~match_q & ~i_alarm_wr_en;

`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam int SC_W = $clog2(MAX_SNOOZES + 1);
   logic [SC_W-1:0] snooze_cnt;

   assign snooze_ok = (snooze_cnt != SC_W'(MAX_SNOOZES));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         snooze_cnt <= '0;
      end else if (state_d == ARMED || state_d == DISARMED) begin
         snooze_cnt <= '0;
      end else if (state_q == RINGING && state_d == SNOOZING) begin
         snooze_cnt <= snooze_cnt + 1'b1;
      end
   end
`else
   // Unlimited snooze; the limit parameter has no effect in this build.
   assign snooze_ok = (MAX_SNOOZES != 0) | 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      ring_d  = ring_cnt;
      snz_d   = snz_cnt;
      case (state_q)
         DISARMED: begin
            if (i_arm_toggle) state_d = ARMED;
         end
         ARMED: begin
            if (i_arm_toggle) begin
               state_d = DISARMED;
            end else if (match_rise) begin
               state_d = RINGING;
               ring_d  = RING_LOAD;
            end
         end
         RINGING: begin
            if (i_stop) begin
               state_d = ARMED;
            end else if (i_arm_toggle) begin
               state_d = DISARMED;
            end else if (i_snooze && snooze_ok) begin
               state_d = SNOOZING;
               snz_d   = SNZ_LOAD;
            end else if (i_tick_1hz) begin
               if (ring_cnt == 16'd1) state_d = ARMED;
               else                   ring_d  = ring_cnt - 16'd1;
            end
         end
         SNOOZING: begin
            if (i_stop) begin
               state_d = ARMED;
            end else if (i_arm_toggle) begin
               state_d = DISARMED;
            end else if (i_tick_1hz) begin
               if (snz_cnt == 16'd1) begin
                  state_d = RINGING;
                  ring_d  = RING_LOAD;
               end else begin
                  snz_d   = snz_cnt - 16'd1;
               end
            end
         end
         default: state_d = DISARMED;
      endcase
      if (state_d != RINGING)  ring_d = '0;
      if (state_d != SNOOZING) snz_d  = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= DISARMED;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         match_q  <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ring_cnt <= ring_d;
         snz_cnt  <= snz_d;
         match_q  <= (i_cur_time == i_alarm_time);
         armed_q  <= (state_d != DISARMED);
      end
   end

   // Enable drops on the entry and exit edges so the phase register alone is the buzzer.
   assign beep_en = (state_q == RINGING) && (state_d == RINGING);

   alarm_beep_gen #(
      .BEEP_HALF_PERIOD(BEEP_HALF_PERIOD)
   ) u_beep (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (beep_en),
      .o_beep (o_buzzer)
   );

   assign o_state            = state_q;
   assign o_armed            = armed_q;
   assign o_snooze_remaining = snz_cnt;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed testbench for alarm_ctrl (SNOOZE=3, RING_TIMEOUT=4, BEEP_HALF_PERIOD=1).
module tb_alarm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic [19:0] cur_time = '0;
   logic [19:0] alarm_time = '0;
   logic        wr_en = 1'b0;
   logic        arm = 1'b0;
   logic        snooze = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  state;
   logic        buzzer;
   logic        armed;
   logic [15:0] snz_rem;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [1:0] S_DIS = 2'd0, S_ARM = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

   always #5 clk = ~clk;

   alarm_ctrl #(
      .SNOOZE_SECONDS      (3),
      .RING_TIMEOUT_SECONDS(4),
      .BEEP_HALF_PERIOD    (1),
      .MAX_SNOOZES         (2)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_tick_1hz        (tick),
      .i_cur_time        (cur_time),
      .i_alarm_time      (alarm_time),
      .i_alarm_wr_en     (wr_en),
      .i_arm_toggle      (arm),
      .i_snooze          (snooze),
      .i_stop            (stop),
      .o_state           (state),
      .o_buzzer          (buzzer),
      .o_armed           (armed),
      .o_snooze_remaining(snz_rem)
   );

   function automatic logic [19:0] t(input int h, input int m, input int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Apply single-cycle pulses for one edge, then release them.
   task automatic pulse(input logic p_tick, input logic p_arm, input logic p_snz, input logic p_stop);
      tick = p_tick; arm = p_arm; snooze = p_snz; stop = p_stop;
      cyc();
      tick = 1'b0; arm = 1'b0; snooze = 1'b0; stop = 1'b0;
   endtask

   task automatic ring_up();
      cur_time = t(7, 29, 59);
      cyc();
      cur_time = t(7, 30, 0);
      cyc();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cur_time   = t(7, 29, 59);
      alarm_time = t(7, 30, 0);
      cyc(); cyc();
      chk("rst_state", 32'(state), 32'(S_DIS));
      chk("rst_buzzer", 32'(buzzer), 0);
      chk("rst_armed", 32'(armed), 0);
      chk("rst_snz", 32'(snz_rem), 0);
      rst_n = 1'b1;
      cyc();

      pulse(0, 1, 0, 0);
      chk("arm_state", 32'(state), 32'(S_ARM));
      chk("arm_armed", 32'(armed), 1);

      cur_time = t(7, 30, 0);
      cyc();
      chk("ring_entry", 32'(state), 32'(S_RING));
      chk("beep_c0", 32'(buzzer), 0);
      cyc();
      chk("beep_c1", 32'(buzzer), 1);
      cyc();
      chk("beep_c2", 32'(buzzer), 0);
      cyc();
      chk("beep_c3", 32'(buzzer), 1);

      for (int i = 1; i <= 4; i++) begin
         pulse(1, 0, 0, 0);
         chk("timeout_state", 32'(state), (i < 4) ? 32'(S_RING) : 32'(S_ARM));
      end
      chk("timeout_buzzer", 32'(buzzer), 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("no_retrigger", 32'(state), 32'(S_ARM));
      end

      ring_up();
      chk("ring2", 32'(state), 32'(S_RING));
      pulse(0, 0, 1, 0);
      chk("snz_state", 32'(state), 32'(S_SNZ));
      chk("snz_rem3", 32'(snz_rem), 3);
      chk("snz_buzzer", 32'(buzzer), 0);
      pulse(1, 0, 0, 0);
      chk("snz_rem2", 32'(snz_rem), 2);
      pulse(1, 0, 0, 0);
      chk("snz_rem1", 32'(snz_rem), 1);
      pulse(1, 0, 0, 0);
      chk("snz_wake", 32'(state), 32'(S_RING));
      chk("snz_rem0", 32'(snz_rem), 0);
      for (int i = 1; i <= 4; i++) begin
         pulse(1, 0, 0, 0);
         chk("reload_timeout", 32'(state), (i < 4) ? 32'(S_RING) : 32'(S_ARM));
      end

      ring_up();
      pulse(1, 0, 0, 1);
      chk("stop_tick", 32'(state), 32'(S_ARM));
      chk("stop_buzzer", 32'(buzzer), 0);

      cur_time = t(7, 29, 59);
      cyc();
      cur_time = t(7, 30, 0);
      pulse(0, 1, 0, 0);
      chk("match_arm", 32'(state), 32'(S_DIS));
      chk("match_arm_armed", 32'(armed), 0);
      cyc();
      chk("match_arm_buz", 32'(buzzer), 0);

      pulse(0, 1, 0, 0);
      cur_time = t(8, 0, 0);
      cyc();
      alarm_time = t(8, 0, 0);
      wr_en = 1'b1;
      cyc();
      wr_en = 1'b0;
      chk("edit_no_ring0", 32'(state), 32'(S_ARM));
      cyc();
      chk("edit_no_ring1", 32'(state), 32'(S_ARM));

      cur_time = t(8, 0, 1);
      cyc();
      cur_time = t(8, 0, 0);
      cyc();
      chk("ring3", 32'(state), 32'(S_RING));
      cyc();
      chk("ring3_buz", 32'(buzzer), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_buz", 32'(buzzer), 0);
      chk("async_rst_state", 32'(state), 32'(S_DIS));
      cyc();
      rst_n = 1'b1;

`ifdef ALARM_SNOOZE_LIMIT_EN
      alarm_time = t(7, 30, 0);
      cyc();
      pulse(0, 1, 0, 0);
      ring_up();
      for (int k = 0; k < 2; k++) begin
         pulse(0, 0, 1, 0);
         chk("lim_snz", 32'(state), 32'(S_SNZ));
         for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
         chk("lim_wake", 32'(state), 32'(S_RING));
      end
      pulse(0, 0, 1, 0);
      chk("lim_ignored", 32'(state), 32'(S_RING));
      for (int i = 1; i <= 4; i++) begin
         pulse(1, 0, 0, 0);
         chk("lim_timeout", 32'(state), (i < 4) ? 32'(S_RING) : 32'(S_ARM));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
